// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin processor ownership plus snoop/memory secondary grants.
// Optional forced release of long-held processor grants when ARB_TIMEOUT_EN is defined.
module com_bus_arbiter #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    input  logic                 Mem_snoop_req,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    output logic                 Mem_snoop_gnt,
    output logic                 Arb_timeout
);

    localparam int unsigned NP = NUM_PROC;
    localparam int unsigned NS = NUM_SNOOP;
    localparam int PW = $clog2(NUM_PROC);
    localparam int SW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;

    if (NUM_PROC < 2 || NUM_PROC > 16 || NUM_SNOOP < 1 || NUM_SNOOP > 16 ||
        TIMEOUT < 2 || TIMEOUT > 1024) begin : g_param_check
        $error("com_bus_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {IDLE, PROC_OWN, PROC_SNOOP, PROC_MEM} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       last_gnt, last_gnt_n;
    logic [SW-1:0]       snp_idx, snp_idx_n;
    logic [NUM_PROC-1:0] gnt_proc_n;
    logic [NUM_SNOOP-1:0] gnt_snoop_n;
    logic                mem_gnt_n;

    logic [NUM_PROC-1:0] skip_mask;
    logic [NUM_PROC-1:0] req_avail;
    logic                tmo_hit;
    logic                owner_req;
    logic                rr_found;
    logic [PW-1:0]       rr_idx, rr_cand;
    logic                snp_any;
    logic [SW-1:0]       snp_lo;

    assign req_avail = Com_Bus_Req_proc & ~skip_mask;
    assign owner_req = Com_Bus_Req_proc[last_gnt];

    // Round-robin: first available requester after the last owner, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned i = 1; i <= NP; i++) begin
            rr_cand = PW'((32'(last_gnt) + i) % NP);
            if (!rr_found && req_avail[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Lowest-index snoop requester, never the owner's own core.
    always_comb begin
        snp_any = 1'b0;
        snp_lo  = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            if (!snp_any && Com_Bus_Req_snoop[j] && ((32'(last_gnt) >> 1) != j)) begin
                snp_any = 1'b1;
                snp_lo  = SW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last_gnt          <= PW'(NP - 1);
            snp_idx           <= '0;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
        end else begin
            state             <= state_n;
            last_gnt          <= last_gnt_n;
            snp_idx           <= snp_idx_n;
            Com_Bus_Gnt_proc  <= gnt_proc_n;
            Com_Bus_Gnt_snoop <= gnt_snoop_n;
            Mem_snoop_gnt     <= mem_gnt_n;
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (rr_found) state_n = PROC_OWN;
        end else if (!owner_req || tmo_hit) begin
            state_n = IDLE;
        end else begin
            case (state)
                PROC_OWN: begin
                    if (snp_any)            state_n = PROC_SNOOP;
                    else if (Mem_snoop_req) state_n = PROC_MEM;
                end
                PROC_SNOOP: if (!Com_Bus_Req_snoop[snp_idx]) state_n = PROC_OWN;
                PROC_MEM:   if (!Mem_snoop_req)              state_n = PROC_OWN;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_proc_n  = '0;
        gnt_snoop_n = '0;
        last_gnt_n  = last_gnt;
        snp_idx_n   = snp_idx;
        if (state == IDLE && rr_found) last_gnt_n = rr_idx;
        if (state == PROC_OWN && state_n == PROC_SNOOP) snp_idx_n = snp_lo;
        if (state_n != IDLE) gnt_proc_n[last_gnt_n] = 1'b1;
        if (state_n == PROC_SNOOP) gnt_snoop_n[snp_idx_n] = 1'b1;
        mem_gnt_n = (state_n == PROC_MEM);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] hold_cnt;

    assign tmo_hit = (state != IDLE) && owner_req && (hold_cnt == CW'(TIMEOUT - 1));

    // The timed-out owner is masked for exactly one IDLE search, then released.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt    <= '0;
            skip_mask   <= '0;
            Arb_timeout <= 1'b0;
        end else begin
            Arb_timeout <= tmo_hit;
            if (state == IDLE || state_n == IDLE) hold_cnt <= '0;
            else                                  hold_cnt <= hold_cnt + 1'b1;
            if (tmo_hit)            skip_mask <= NUM_PROC'(1) << last_gnt;
            else if (state == IDLE) skip_mask <= '0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign skip_mask   = '0;
    assign Arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Randomized and directed bench for com_bus_arbiter against an ownership-level reference model.
module tb_com_bus_arbiter;

    localparam int NP  = 8;
    localparam int NS  = 4;
    localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req_proc = '0;
    logic [NS-1:0] req_snoop = '0;
    logic          mem_req = 1'b0;
    logic [NP-1:0] gnt_proc;
    logic [NS-1:0] gnt_snoop;
    logic          mem_gnt;
    logic          arb_tmo;

    com_bus_arbiter #(.NUM_PROC(NP), .NUM_SNOOP(NS), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Mem_snoop_req     (mem_req),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_gnt     (mem_gnt),
        .Arb_timeout       (arb_tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 none), secondary kind (0 none, 1 snoop, 2 memory).
    int m_owner = -1, m_sec = 0, m_sidx = 0, m_last = NP - 1, m_cnt = 0, m_skip = -1;
    bit m_tmo = 1'b0;
    bit armed = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            m_owner = -1; m_sec = 0; m_last = NP - 1; m_cnt = 0; m_skip = -1; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    int c;
                    c = (m_last + k) % NP;
                    if (m_owner < 0 && req_proc[c] && c != m_skip) begin
                        m_owner = c; m_last = c; m_cnt = 0;
                    end
                end
                m_skip = -1;
            end else if (!req_proc[m_owner]) begin
                m_owner = -1; m_sec = 0;
            end else if (TMO_EN && m_cnt == TMO - 1) begin
                m_tmo = 1'b1; m_skip = m_owner; m_owner = -1; m_sec = 0;
            end else begin
                m_cnt++;
                if (m_sec == 0) begin
                    for (int j = NS - 1; j >= 0; j--)
                        if (req_snoop[j] && j != m_owner / 2) begin m_sec = 1; m_sidx = j; end
                    if (m_sec == 0 && mem_req) m_sec = 2;
                end else if (m_sec == 1) begin
                    if (!req_snoop[m_sidx]) m_sec = 0;
                end else begin
                    if (!mem_req) m_sec = 0;
                end
            end
        end
    end

    bit rec_on = 1'b0;
    int order[$];
    logic [NP-1:0] prev_p = '0;

    always @(negedge clk) begin
        if (armed) begin
            check("gnt_proc", 32'(gnt_proc), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("gnt_snoop", 32'(gnt_snoop), (m_sec == 1) ? (32'd1 << m_sidx) : 32'd0);
            check("mem_gnt", 32'(mem_gnt), 32'(m_sec == 2));
            check("arb_timeout", 32'(arb_tmo), 32'(m_tmo));
            if (rec_on && gnt_proc != '0 && prev_p == '0)
                for (int i = 0; i < NP; i++) if (gnt_proc[i]) order.push_back(i);
            prev_p = gnt_proc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input logic [NP-1:0] exp, input string name);
        int n = 0;
        while (gnt_proc == '0 && n < 50) begin tick(); n++; end
        check(name, 32'(gnt_proc), 32'(exp));
    endtask

    initial begin
        int hc;
        rst = 1'b1;
        tick(); tick();
        check("reset_proc", 32'(gnt_proc), 32'h0);
        check("reset_snoop", 32'(gnt_snoop), 32'h0);
        check("reset_mem", 32'(mem_gnt), 32'h0);
        check("reset_tmo", 32'(arb_tmo), 32'h0);

        // Round-robin order with all requesters active.
        rst = 1'b0; req_proc = '1; rec_on = 1'b1; hc = 0;
        for (int cyc = 0; cyc < 200 && order.size() < 9; cyc++) begin
            tick();
            if (gnt_proc != '0) begin
                hc++;
                if (hc == 3) req_proc = req_proc & ~gnt_proc;
            end else begin
                req_proc = '1; hc = 0;
            end
        end
        rec_on = 1'b0;
        check("rr_count", 32'(order.size()), 32'd9);
        for (int i = 0; i < order.size() && i < 9; i++) check("rr_order", 32'(order[i]), 32'(i % 8));

        // Own-core snoop exclusion and snoop-over-memory priority.
        do_reset();
        req_proc = 8'h04;
        wait_gnt(8'h04, "own2");
        req_snoop = 4'b1010; mem_req = 1'b1;
        tick();
        check("snoop3_gnt", 32'(gnt_snoop), 32'h8);
        check("snoop3_mem", 32'(mem_gnt), 32'h0);
        tick(); tick();
        check("snoop3_hold", 32'(gnt_snoop), 32'h8);
        req_snoop = 4'b0010;
        tick();
        check("snoop3_rel", 32'(gnt_snoop), 32'h0);
        check("snoop3_rel_mem", 32'(mem_gnt), 32'h0);
        check("snoop3_owner", 32'(gnt_proc), 32'h04);
        tick();
        check("mem_gnt_after", 32'(mem_gnt), 32'h1);
        check("mem_no_snoop1", 32'(gnt_snoop), 32'h0);

        // Owner drop clears everything.
        do_reset();
        req_proc = 8'h20;
        wait_gnt(8'h20, "own5");
        req_snoop = 4'b0001;
        tick();
        check("snoop0_gnt", 32'(gnt_snoop), 32'h1);
        req_proc = '0;
        tick();
        check("drop_proc", 32'(gnt_proc), 32'h0);
        check("drop_snoop", 32'(gnt_snoop), 32'h0);

        // Reset in PROC_SNOOP, then immediate regrant after release.
        do_reset();
        req_proc = 8'h20;
        wait_gnt(8'h20, "own5b");
        req_snoop = 4'b0001;
        tick();
        rst = 1'b1;
        tick();
        check("rst_proc", 32'(gnt_proc), 32'h0);
        check("rst_snoop", 32'(gnt_snoop), 32'h0);
        rst = 1'b0; req_proc = 8'h10; req_snoop = '0;
        tick();
        check("post_rst_gnt", 32'(gnt_proc), 32'h10);

        // Long hold by proc 3 with proc 4 waiting.
        do_reset();
        req_proc = 8'h18;
        wait_gnt(8'h08, "own3");
        if (TMO_EN) begin
            for (int i = 0; i < TMO - 1; i++) begin
                tick();
                check("tmo_hold", 32'(gnt_proc), 32'h08);
            end
            tick();
            check("tmo_drop", 32'(gnt_proc), 32'h0);
            check("tmo_pulse", 32'(arb_tmo), 32'h1);
            tick();
            check("tmo_next", 32'(gnt_proc), 32'h10);
            check("tmo_pulse_end", 32'(arb_tmo), 32'h0);
        end else begin
            repeat (20) tick();
            check("no_tmo_hold", 32'(gnt_proc), 32'h08);
            check("no_tmo_pulse", 32'(arb_tmo), 32'h0);
        end

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NP; i++) if ($urandom_range(0, 7) == 0) req_proc[i] = ~req_proc[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 4) == 0) req_snoop[i] = ~req_snoop[i];
            if ($urandom_range(0, 4) == 0) mem_req = ~mem_req;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
